// File: rtl/sobel_pkg.sv
// Shared constants, state encoding and window indexing for the Sobel scan stage.
package sobel_pkg;

  localparam int DEF_IMG_W  = 64;
  localparam int DEF_IMG_H  = 64;
  localparam int DEF_PIX_W  = 8;
  localparam int DEF_ADDR_W = 12;

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } scan_state_e;

  // Flat slot of window pixel (row i, column j); slot 0 is top-left.
  function automatic int win_idx(input int i, input int j);
    return 3 * i + j;
  endfunction

endpackage

// File: rtl/sobel_scan_if.sv
// Bus between the scan unit and its memory/controller/gradient neighbours.
// With SOBEL_WINCNT_EN defined the debug window counter Win_Cnt is carried as well.
interface sobel_scan_if #(
  parameter int ADDR_W = 12,
  parameter int PIX_W  = 8
);

  logic                 Enable;
  logic [ADDR_W-1:0]    Rd_Addr;
  logic [PIX_W-1:0]     Rd_Data;
  logic [9*PIX_W-1:0]   Win;
  logic                 Win_Valid;
  logic [ADDR_W-1:0]    Wr_Addr;
  logic                 isEnd;
`ifdef SOBEL_WINCNT_EN
  logic [ADDR_W-1:0]    Win_Cnt;

  modport master (
    input  Enable, Rd_Data,
    output Rd_Addr, Win, Win_Valid, Wr_Addr, isEnd, Win_Cnt
  );

  modport slave (
    output Enable, Rd_Data,
    input  Rd_Addr, Win, Win_Valid, Wr_Addr, isEnd, Win_Cnt
  );
`else
  modport master (
    input  Enable, Rd_Data,
    output Rd_Addr, Win, Win_Valid, Wr_Addr, isEnd
  );

  modport slave (
    output Enable, Rd_Data,
    input  Rd_Addr, Win, Win_Valid, Wr_Addr, isEnd
  );
`endif

endinterface

// File: rtl/sobel_line_buffer.sv
// One image row of pixels, indexed by column, with combinational read and
// synchronous write/clear.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_W,
  parameter int WIDTH = DEF_PIX_W,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] idx,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: clearing every entry on reset forces flops rather than RAM; it is kept
  // because a restarted scan must never see pixels from an aborted one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[idx] <= wr_data;
    end
  end

  assign rd_data = mem[idx];

endmodule

// File: rtl/sobel_scan_unit.sv
// Raster-scans the source image, builds 3x3 windows from two line buffers and
// emits each interior window with its centre address. Optional: SOBEL_WINCNT_EN.
module sobel_scan_unit
  import sobel_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int PIX_W  = DEF_PIX_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic         CLK,
  input  logic         Reset,
  sobel_scan_if.master bus
);

  localparam int                COL_W    = $clog2(IMG_W);
  localparam int                ROW_W    = $clog2(IMG_H);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] CTR_OFS  = ADDR_W'(IMG_W + 1);

  scan_state_e              state;
  logic [ROW_W-1:0]         row;
  logic [COL_W-1:0]         col;
  logic [ADDR_W-1:0]        rd_addr;
  logic                     rd_vld;
  logic                     rd_int;
  logic [COL_W-1:0]         rd_col;
  logic [ADDR_W-1:0]        rd_tag;
  logic [8:0][PIX_W-1:0]    win;
  logic                     win_valid;
  logic [ADDR_W-1:0]        wr_addr;
  logic                     is_end;
  logic [PIX_W-1:0]         lb0_q;
  logic [PIX_W-1:0]         lb1_q;
  logic                     fire;
  logic                     scan_last;

  assign fire      = (state == SCAN) && bus.Enable;
  assign scan_last = (row == ROW_LAST) && (col == COL_LAST);

  // lb0 holds the previous row, lb1 the one above it, both at the returned column.
  sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .IDX_W(COL_W)) u_lb0 (
    .clk     (CLK),
    .rst_n   (Reset),
    .wr_en   (rd_vld),
    .idx     (rd_col),
    .wr_data (bus.Rd_Data),
    .rd_data (lb0_q)
  );

  sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .IDX_W(COL_W)) u_lb1 (
    .clk     (CLK),
    .rst_n   (Reset),
    .wr_en   (rd_vld),
    .idx     (rd_col),
    .wr_data (lb0_q),
    .rd_data (lb1_q)
  );

  // NOTE: all state here uses non-blocking assignment so every register samples
  // the pre-edge values, which is what lets the window shift read the old slots.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state     <= SCAN;
      row       <= '0;
      col       <= '0;
      rd_addr   <= '0;
      rd_vld    <= 1'b0;
      rd_int    <= 1'b0;
      rd_col    <= '0;
      rd_tag    <= '0;
      win       <= '0;
      win_valid <= 1'b0;
      wr_addr   <= '0;
      is_end    <= 1'b0;
    end else begin
      win_valid <= 1'b0;
      unique case (state)
        SCAN: begin
          if (fire) begin
            if (scan_last) begin
              state <= DRAIN;
            end else begin
              rd_addr <= rd_addr + ADDR_W'(1);
              if (col == COL_LAST) begin
                col <= '0;
                row <= row + ROW_W'(1);
              end else begin
                col <= col + COL_W'(1);
              end
            end
          end
        end
        // The last read returns one cycle after leaving SCAN; once it is consumed
        // the final window is on the outputs and the scan is complete.
        DRAIN: begin
          if (!rd_vld) begin
            state  <= DONE;
            is_end <= 1'b1;
          end
        end
        DONE:    is_end <= 1'b1;
        default: state  <= DONE;
      endcase

      rd_vld <= fire;
      if (fire) begin
        rd_col <= col;
        rd_tag <= rd_addr;
        rd_int <= (row >= ROW_W'(2)) && (col >= COL_W'(2));
      end

      if (rd_vld) begin
        for (int i = 0; i < 3; i++) begin
          win[win_idx(i, 0)] <= win[win_idx(i, 1)];
          win[win_idx(i, 1)] <= win[win_idx(i, 2)];
        end
        win[win_idx(0, 2)] <= lb1_q;
        win[win_idx(1, 2)] <= lb0_q;
        win[win_idx(2, 2)] <= bus.Rd_Data;
        // Columns 0/1 still hold the previous row's tail, so they never qualify.
        if (rd_int) begin
          win_valid <= 1'b1;
          wr_addr   <= rd_tag - CTR_OFS;
        end
      end
    end
  end

`ifdef SOBEL_WINCNT_EN
  logic [ADDR_W-1:0] win_cnt;

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      win_cnt <= '0;
    end else if (rd_vld && rd_int && (win_cnt != '1)) begin
      win_cnt <= win_cnt + ADDR_W'(1);
    end
  end

  assign bus.Win_Cnt = win_cnt;
`endif

  assign bus.Rd_Addr   = rd_addr;
  assign bus.Win       = win;
  assign bus.Win_Valid = win_valid;
  assign bus.Wr_Addr   = wr_addr;
  assign bus.isEnd     = is_end;

endmodule

// File: tb/tb_sobel_scan_unit.sv
// Bench for sobel_scan_unit: a 4x4 and a 5x3 instance checked every cycle
// against a raster/window model, plus literal expectations for known images.
`timescale 1ns/1ps
module tb_sobel_scan_unit;

  localparam int AW = 12;
  localparam int PW = 8;
  localparam int W0 = 4;
  localparam int H0 = 4;
  localparam int W1 = 5;
  localparam int H1 = 3;

  typedef struct {
    int               cyc;
    logic [9*PW-1:0]  win;
    logic [AW-1:0]    wa;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    rst_v = '0;
  logic [1:0]    en_v  = '0;
  logic [PW-1:0] mem [2][64];
  logic [PW-1:0] rd_q [2];

  sobel_scan_if #(.ADDR_W(AW), .PIX_W(PW)) if_a ();
  sobel_scan_if #(.ADDR_W(AW), .PIX_W(PW)) if_b ();

  assign if_a.Enable  = en_v[0];
  assign if_a.Rd_Data = rd_q[0];
  assign if_b.Enable  = en_v[1];
  assign if_b.Rd_Data = rd_q[1];

  sobel_scan_unit #(.IMG_W(W0), .IMG_H(H0), .PIX_W(PW), .ADDR_W(AW)) dut_a (
    .CLK   (clk),
    .Reset (rst_v[0]),
    .bus   (if_a.master)
  );

  sobel_scan_unit #(.IMG_W(W1), .IMG_H(H1), .PIX_W(PW), .ADDR_W(AW)) dut_b (
    .CLK   (clk),
    .Reset (rst_v[1]),
    .bus   (if_b.master)
  );

  // Synchronous source memories: data for the address seen at an edge appears after it.
  always @(posedge clk) begin
    rd_q[0] <= mem[0][if_a.Rd_Addr[5:0]];
    rd_q[1] <= mem[1][if_b.Rd_Addr[5:0]];
  end

  logic [AW-1:0]   o_rd  [2];
  logic [AW-1:0]   o_wa  [2];
  logic [9*PW-1:0] o_win [2];
  logic            o_vld [2];
  logic            o_end [2];
  assign o_rd[0]  = if_a.Rd_Addr;   assign o_rd[1]  = if_b.Rd_Addr;
  assign o_wa[0]  = if_a.Wr_Addr;   assign o_wa[1]  = if_b.Wr_Addr;
  assign o_win[0] = if_a.Win;       assign o_win[1] = if_b.Win;
  assign o_vld[0] = if_a.Win_Valid; assign o_vld[1] = if_b.Win_Valid;
  assign o_end[0] = if_a.isEnd;     assign o_end[1] = if_b.isEnd;
`ifdef SOBEL_WINCNT_EN
  logic [AW-1:0]   o_cnt [2];
  assign o_cnt[0] = if_a.Win_Cnt;   assign o_cnt[1] = if_b.Win_Cnt;
`endif

  int              n_tests = 0;
  int              n_fail  = 0;
  int              fires    [2];
  int              cyc      [2];
  int              end_cyc  [2];
  int              first_v  [2];
  int              end_rise [2];
  bit              armed    [2] = '{1'b0, 1'b0};
  logic [9*PW-1:0] first_win [2];
  ev_t             q0 [$];
  ev_t             q1 [$];
  logic [AW-1:0]   wa_log0 [$];
  logic [AW-1:0]   wa_log1 [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic int img_w(input int u);
    return (u == 0) ? W0 : W1;
  endfunction

  function automatic int img_h(input int u);
    return (u == 0) ? H0 : H1;
  endfunction

  // Window centred on (cr, cc) taken straight from the image.
  function automatic logic [9*PW-1:0] golden_win(input int u, input int cr, input int cc);
    logic [9*PW-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(3*i+j)*PW +: PW] = mem[u][(cr-1+i)*img_w(u) + (cc-1+j)];
    return w;
  endfunction

  // Compare at the falling edge, then advance the model with this cycle's inputs.
  initial begin : compare
    int  n;
    int  a;
    int  r;
    int  c;
    bit  due;
    ev_t ev;
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        n = img_w(u) * img_h(u);
        if (armed[u]) begin
          check($sformatf("u%0d cyc%0d rd_addr", u, cyc[u]), o_rd[u],
                (fires[u] < n) ? fires[u] : n - 1);
          if (u == 0) begin
            due = (q0.size() > 0) && (q0[0].cyc == cyc[0]);
            if (due) ev = q0.pop_front();
          end else begin
            due = (q1.size() > 0) && (q1[0].cyc == cyc[1]);
            if (due) ev = q1.pop_front();
          end
          check($sformatf("u%0d cyc%0d win_valid", u, cyc[u]), o_vld[u], due);
          if (due) begin
            check($sformatf("u%0d cyc%0d win", u, cyc[u]), o_win[u], ev.win);
            check($sformatf("u%0d cyc%0d wr_addr", u, cyc[u]), o_wa[u], ev.wa);
          end
          if (o_vld[u] === 1'b1) begin
            if (first_v[u] < 0) begin
              first_v[u]   = cyc[u];
              first_win[u] = o_win[u];
            end
            if (u == 0) wa_log0.push_back(o_wa[u]);
            else        wa_log1.push_back(o_wa[u]);
          end
          check($sformatf("u%0d cyc%0d is_end", u, cyc[u]), o_end[u],
                (end_cyc[u] >= 0) && (cyc[u] >= end_cyc[u]));
          if (o_end[u] === 1'b1 && end_rise[u] < 0) end_rise[u] = cyc[u];
          if (cyc[u] == 0) begin
            check($sformatf("u%0d reset win", u), o_win[u], '0);
            check($sformatf("u%0d reset wr_addr", u), o_wa[u], '0);
`ifdef SOBEL_WINCNT_EN
            check($sformatf("u%0d reset win_cnt", u), o_cnt[u], '0);
`endif
          end
        end

        if (!rst_v[u]) begin
          armed[u]    = 1'b1;
          fires[u]    = 0;
          cyc[u]      = 0;
          end_cyc[u]  = -1;
          first_v[u]  = -1;
          end_rise[u] = -1;
          if (u == 0) begin q0.delete(); wa_log0.delete(); end
          else        begin q1.delete(); wa_log1.delete(); end
        end else if (armed[u]) begin
          if (en_v[u] && fires[u] < n) begin
            a = fires[u];
            r = a / img_w(u);
            c = a % img_w(u);
            if (r >= 2 && c >= 2) begin
              ev.cyc = cyc[u] + 2;
              ev.win = golden_win(u, r - 1, c - 1);
              ev.wa  = AW'((r - 1) * img_w(u) + (c - 1));
              if (u == 0) q0.push_back(ev);
              else        q1.push_back(ev);
            end
            if (a == n - 1) end_cyc[u] = cyc[u] + 3;
            fires[u]++;
          end
          cyc[u]++;
        end
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode 0: Enable always high, 1: low in cycles 5-7, 2: random.
  // Enable is held high during reset to exercise reset priority.
  task automatic scan(input int u, input int mode, input int budget);
    rst_v[u] = 1'b0;
    en_v[u]  = 1'b1;
    tick(1);
    rst_v[u] = 1'b1;
    for (int k = 0; k < budget; k++) begin
      case (mode)
        0:       en_v[u] = 1'b1;
        1:       en_v[u] = !(k >= 5 && k <= 7);
        default: en_v[u] = ($urandom_range(0, 3) != 0);
      endcase
      tick(1);
      if (end_rise[u] >= 0 && k >= end_rise[u] + 10) break;
    end
    en_v[u] = 1'b0;
    n_tests++;
    if (end_rise[u] < 0) begin
      n_fail++;
      $display("FAIL u%0d scan timeout: isEnd never rose within %0d cycles", u, budget);
    end
  endtask

  task automatic check_wa0(input string tag, input int e0, input int e1, input int e2, input int e3);
    int exp_wa [4];
    exp_wa = '{e0, e1, e2, e3};
    check({tag, " window count"}, wa_log0.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s wr_addr #%0d", tag, i),
            (i < wa_log0.size()) ? wa_log0[i] : '1, exp_wa[i]);
  endtask

  initial begin : main
    int              lv [9];
    logic [9*PW-1:0] lit;
    lv  = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    lit = '0;
    for (int k = 0; k < 9; k++) lit[k*PW +: PW] = PW'(lv[k]);
    for (int a = 0; a < 64; a++) begin
      mem[0][a] = PW'(a);
      mem[1][a] = PW'($urandom);
    end
    tick(2);

    // 4x4 ramp image, Enable always high.
    scan(0, 0, 60);
    check("ramp first valid cycle", first_v[0], 12);
    check("ramp first window", first_win[0], lit);
    check("ramp isEnd cycle", end_rise[0], 18);
    check_wa0("ramp", 5, 6, 9, 10);
`ifdef SOBEL_WINCNT_EN
    check("ramp win_cnt", o_cnt[0], 4);
`endif

    // Enable low in cycles 5-7: same windows, three cycles later.
    scan(0, 1, 60);
    check("pause first valid cycle", first_v[0], 15);
    check("pause first window", first_win[0], lit);
    check("pause isEnd cycle", end_rise[0], 21);
    check_wa0("pause", 5, 6, 9, 10);

    // Reset during cycle 9 of a scan, then a clean restart.
    rst_v[0] = 1'b0;
    tick(1);
    rst_v[0] = 1'b1;
    en_v[0]  = 1'b1;
    tick(9);
    rst_v[0] = 1'b0;
    tick(1);
    check("midreset win", o_win[0], '0);
    check("midreset rd_addr", o_rd[0], '0);
    check("midreset win_valid", o_vld[0], 1'b0);
    check("midreset is_end", o_end[0], 1'b0);
    scan(0, 0, 60);
    check("restart first valid cycle", first_v[0], 12);
    check("restart first window", first_win[0], lit);
    check_wa0("restart", 5, 6, 9, 10);

    // Random image and random Enable on the 4x4 unit.
    for (int a = 0; a < 64; a++) mem[0][a] = PW'($urandom);
    scan(0, 2, 200);
    check_wa0("random4x4", 5, 6, 9, 10);

    // 5x3 unit with random pixels and random Enable.
    scan(1, 2, 200);
    check("5x3 window count", wa_log1.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("5x3 wr_addr #%0d", i),
            (i < wa_log1.size()) ? wa_log1[i] : '1, 6 + i);
    check("5x3 first window", first_win[1], golden_win(1, 1, 1));
`ifdef SOBEL_WINCNT_EN
    check("5x3 win_cnt", o_cnt[1], 3);
`endif

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_scan_unit.md
Name: sobel_scan_unit

Overview:
- Datapath scan stage driven directly by the Sobel controller: consumes its Reset (active-low clear) and Enable, and returns isEnd.
- Raster-scans the source image memory and issues one read per enabled cycle.
- Assembles a 3x3 pixel window with two line buffers and presents each interior window, with its output address, to the downstream gradient stage.

Parameters:
- IMG_W, 64, image width in pixels (>=3)
- IMG_H, 64, image height in pixels (>=3)
- PIX_W, 8, bits per pixel
- ADDR_W, 12, memory address width (2**ADDR_W >= IMG_W*IMG_H)

Ports:
- CLK  in  1  clock, all logic on rising edge
- Reset  in  1  synchronous, active-low; driven by controller Reset output
- Enable  in  1  scan advance permission from controller
- Rd_Addr  out  ADDR_W  source memory read address
- Rd_Data  in  PIX_W  source pixel, valid the cycle after the read is issued (synchronous RAM)
- Win  out  9*PIX_W  3x3 window; slice Win[PIX_W*(3*i+j) +: PIX_W] = pixel(row ctr-1+i, col ctc-1+j), i.e. slice 0 is top-left
- Win_Valid  out  1  one-cycle pulse per interior window
- Wr_Addr  out  ADDR_W  centre-pixel address for the result write, qualified by Win_Valid
- isEnd  out  1  scan complete, held high until Reset

Behaviour:
- Reset low at a clock edge sets:
  - state=SCAN, row=col=0, Rd_Addr=0
  - Win_Valid=0, isEnd=0, Wr_Addr=0, Win=0
  - read-valid pipeline cleared
  - line buffers cleared to 0
- Reset has priority over Enable and over every state, including mid-scan.
- States:
  - SCAN: fire = Enable. On fire, read addr row*IMG_W+col is presented; col increments, wrapping to 0 with row+1. The fire of the last address (IMG_W*IMG_H-1) moves to DRAIN. Enable low freezes counters (pause), with no read.
  - DRAIN: no new reads; waits for the pipeline to empty (2 cycles), then goes to DONE.
  - DONE: isEnd=1, all outputs otherwise idle; exits only via Reset.
- Rd_Addr is registered.
- A fire in cycle t returns Rd_Data at t+1, tagged with (r,c) via a 1-bit valid and coordinate pipeline. That data is accepted regardless of Enable at t+1.
- On accepted data (r,c):
  - window columns shift left
  - the new right column is {linebuf1[c], linebuf0[c], Rd_Data} (top to bottom)
  - linebuf0[c] <= Rd_Data, linebuf1[c] <= old linebuf0[c]
- Win_Valid=1 at t+2 iff r>=2 and c>=2. Centre is (r-1, c-1) and Wr_Addr = (r-1)*IMG_W + (c-1).
- Border pixels produce no Win_Valid. The row transition (c=0,1) never emits stale cross-row windows.
- Exactly (IMG_W-2)*(IMG_H-2) Win_Valid pulses per scan.
- isEnd rises the cycle after the final Win_Valid (t_last+3) and stays high.
- Address arithmetic is unsigned and truncated to ADDR_W.
- Enable toggling only stretches the schedule; the window sequence is identical.

Optional Feature:
- Macro: SOBEL_WINCNT_EN
- Defined: adds output Win_Cnt [ADDR_W-1:0], cleared by Reset, incremented on each Win_Valid, saturating at all-ones. Used for debug and bench cross-checks.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package sobel_pkg holds:
  - default PIX_W/IMG_W/IMG_H
  - state encoding constants SCAN/DRAIN/DONE
  - window slice index helper (3*i+j)
- Natural sub-module: sobel_line_buffer. It is an IMG_W-deep PIX_W-wide column-indexed buffer with synchronous clear, instantiated twice.

Test Plan:
- IMG_W=IMG_H=4, memory[a]=a, Enable held 1 from cycle 0 after Reset release:
  - Rd_Addr steps 0..15 on cycles 0..15
  - first Win_Valid at cycle 12 with Win={0,1,2,4,5,6,8,9,10} and Wr_Addr=5
  - Win_Valid pulses total 4, with Wr_Addr 5,6,9,10
  - isEnd=1 from cycle 18
- Same image with Enable low for cycles 5-7: Win/Wr_Addr sequence is identical, and each event is delayed 3 cycles.
- Reset low at cycle 9 mid-scan, then restart: outputs return to reset values next edge, and the full correct scan repeats with no stale window data (first Win still {0,1,2,4,5,6,8,9,10}).
- After isEnd, hold Enable=1 for 10 cycles: no reads, no Win_Valid, isEnd stays 1 until Reset.
- IMG_W=5, IMG_H=3, random pixels: 3 windows, Wr_Addr 6,7,8, matching the golden 3x3 model. With SOBEL_WINCNT_EN defined, Win_Cnt=3 at the end.
